fetch_sequencer: RTL

- Sequences instruction fetch. Owns the PC, issues requests on the instruction-memory req/gnt port, and tracks in-flight responses.
- Buffers returned words in a small prefetch FIFO that feeds the decode-side valid/next handshake.
- Sits between the core control (redirects, enable) and the instruction memory. Replaces the always-requesting, always-valid fetch path with credit-based flow control and flush support.

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch constants and state encoding
package core_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOOP = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of {pc, instr} with flush
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_FLUSH,
    input  logic                    i_PUSH,
    input  logic [XLEN-1:0]         i_PUSH_PC,
    input  logic [XLEN-1:0]         i_PUSH_INSTR,
    input  logic                    i_POP,
    output logic [XLEN-1:0]         o_HEAD_PC,
    output logic [XLEN-1:0]         o_HEAD_INSTR,
    output logic [$clog2(DEPTH):0]  o_COUNT,
    output logic                    o_EMPTY,
    output logic                    o_FULL
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign o_EMPTY      = (count == '0);
    assign o_FULL       = (count == (AW+1)'(DEPTH));
    assign o_COUNT      = count;
    assign o_HEAD_PC    = pc_mem[rd_ptr];
    assign o_HEAD_INSTR = instr_mem[rd_ptr];
    assign do_push      = i_PUSH && !i_FLUSH;
    assign do_pop       = i_POP && !o_EMPTY && !i_FLUSH;

    always_ff @(posedge i_CLK) begin
        if (i_RST || i_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge i_CLK) begin
        if (do_push && !i_RST) begin
            pc_mem[wr_ptr]    <= i_PUSH_PC;
            instr_mem[wr_ptr] <= i_PUSH_INSTR;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - credit-based instruction fetch with prefetch FIFO and flush
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_EN,
    input  logic        i_REDIRECT,
    input  logic [31:0] i_REDIRECT_PC,
    output logic        o_IMEM_REQ,
    output logic [31:0] o_IMEM_ADDR,
    input  logic        i_IMEM_GNT,
    input  logic        i_IMEM_RVALID,
    input  logic [31:0] i_IMEM_RDATA,
    input  logic        i_INSTRUCTION_FETCH_NEXT,
    output logic [31:0] o_INSTRUCTION,
    output logic [31:0] o_INSTRUCTION_PC,
    output logic        o_INSTRUCTION_VALID
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_q;
    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;

    logic [CW:0]     credit_used;
    logic            in_run;
    logic            run_redirect;
    logic            grant;
    logic            drop_hit;
    logic            push;
    logic            pop;
    logic            retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = i_EN ? RUN : HALT;
            RUN:     if (!i_EN) state_d = HALT;
            HALT:    if (i_EN)  state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        in_run       = (state_q == RUN);
        run_redirect = i_REDIRECT && in_run;
        credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        o_IMEM_REQ   = in_run && i_EN && !i_REDIRECT && (credit_used < (CW+1)'(DEPTH));
        o_IMEM_ADDR  = pc_q;
        grant        = o_IMEM_REQ && i_IMEM_GNT;
        drop_hit     = i_IMEM_RVALID && (drop_q != '0);
        push         = i_IMEM_RVALID && !drop_hit && !run_redirect;
        pop          = i_INSTRUCTION_FETCH_NEXT && !fifo_empty && !run_redirect;
        // A response arriving with a redirect still retires one in-flight slot.
        retire       = i_IMEM_RVALID && ((drop_q != '0) || (outstanding_q != '0));
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            state_q <= state_d;
            if (i_REDIRECT)
                pc_q <= i_REDIRECT_PC & ~32'd3;
            else if (grant)
                pc_q <= pc_q + 32'd4;

            if (run_redirect) begin
                outstanding_q <= '0;
                drop_q        <= drop_q + outstanding_q - CW'(retire);
                tag_wr_q      <= '0;
                tag_rd_q      <= '0;
            end else begin
                outstanding_q <= outstanding_q + CW'(grant) - CW'(push);
                if (drop_hit) drop_q   <= drop_q - CW'(1);
                if (grant)    tag_wr_q <= tag_wr_q + AW'(1);
                if (push)     tag_rd_q <= tag_rd_q + AW'(1);
            end
        end
    end

    // PC tags follow grants in order so each response is paired with its address.
    always_ff @(posedge i_CLK) begin
        if (grant && !i_RST)
            tag_mem[tag_wr_q] <= pc_q;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST)
            assert (!(push && fifo_full));
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_FLUSH      (run_redirect),
        .i_PUSH       (push),
        .i_PUSH_PC    (tag_mem[tag_rd_q]),
        .i_PUSH_INSTR (i_IMEM_RDATA),
        .i_POP        (pop),
        .o_HEAD_PC    (head_pc),
        .o_HEAD_INSTR (head_instr),
        .o_COUNT      (fifo_count),
        .o_EMPTY      (fifo_empty),
        .o_FULL       (fifo_full)
    );

    assign o_INSTRUCTION_VALID = !fifo_empty;
    assign o_INSTRUCTION       = fifo_empty ? NOOP : head_instr;
    assign o_INSTRUCTION_PC    = fifo_empty ? 32'd0 : head_pc;

endmodule
